// File: rtl/instruction_fetch.sv
// Instruction fetch: sequential PC generation, 1-cycle synchronous imem, 2-entry output queue.
// Latency: request to if_valid is 2 cycles with an empty queue; one instruction per cycle steady state.
// Backpressure: id_ready=0 holds the queue head; requests stop once queued + in-flight words reach the depth.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [63:0] if_pc,
  output logic        fetch_err
);

  typedef enum logic {RUN, ERR} state_t;

  localparam logic [2:0] QFULL = 3'(QDEPTH);

  state_t      state, state_nxt;
  logic [63:0] fetch_pc;
  logic [63:0] inflight_pc;
  logic        inflight;
  logic [1:0]  count;
  logic [31:0] head_inst, tail_inst;
  logic [63:0] head_pc, tail_pc;

  logic        in_run;
  logic        redirect_ok;
  logic        pop;
  logic        push;
  logic        flush;
  logic [2:0]  occupancy;

  // State register; ERR is only left through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next state: a misaligned redirect seen in RUN is fatal, an aligned one restarts fetch.
  always_comb begin
    state_nxt   = state;
    redirect_ok = 1'b0;
    case (state)
      RUN: begin
        if (redirect_valid) begin
          if (redirect_pc[1:0] != 2'b00) state_nxt = ERR;
          else                           redirect_ok = 1'b1;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  // Handshake and request decisions. A redirect wins over pop and response arrival,
  // and the request gate counts the in-flight word so the queue can never overflow.
  always_comb begin
    in_run    = (state == RUN);
    if_valid  = in_run && (count != 2'd0);
    pop       = if_valid && id_ready && !redirect_valid;
    push      = inflight && in_run && !redirect_valid;
    flush     = !in_run || redirect_valid;
    occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    // rst_n gates the request so it reads 0 while reset is held.
    imem_req  = rst_n && in_run && !redirect_valid && (occupancy < QFULL);
    imem_addr = fetch_pc;
    if_inst   = head_inst;
    if_pc     = head_pc;
    fetch_err = (state == ERR);
  end

  // Fetch PC and the single in-flight tracker; the PC wraps naturally at 64 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 64'h0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 64'd4;
      end else if (redirect_ok) begin
        fetch_pc <= redirect_pc;
      end
    end
  end

  // Two-entry queue kept as head/tail registers; the head only moves on a pop,
  // so it stays stable while decode is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      head_inst <= 32'h0;
      head_pc   <= 64'h0;
      tail_inst <= 32'h0;
      tail_pc   <= 64'h0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({pop, push})
        2'b10: begin
          head_inst <= tail_inst;
          head_pc   <= tail_pc;
          count     <= count - 2'd1;
        end
        2'b01: begin
          if (count == 2'd0) begin
            head_inst <= imem_rdata;
            head_pc   <= inflight_pc;
          end else begin
            tail_inst <= imem_rdata;
            tail_pc   <= inflight_pc;
          end
          count <= count + 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_inst <= imem_rdata;
            head_pc   <= inflight_pc;
          end else begin
            head_inst <= tail_inst;
            head_pc   <= tail_pc;
            tail_inst <= imem_rdata;
            tail_pc   <= inflight_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized stall/redirect traffic.
// Expected PCs come from a stream model (start address, +4 per delivered word, restart on redirect).
// A negedge monitor pops the scoreboard on every decode handshake and checks stall stability.
module tb_instruction_fetch;

  localparam logic [63:0] RP = 64'h0;

  logic        clk;
  logic        rst_n;
  logic        id_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        fetch_err;

  instruction_fetch #(.RESET_PC(RP), .QDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  logic [63:0] sb[$];
  logic [63:0] next_exp;
  logic        model_err   = 1'b0;
  logic        err_next    = 1'b0;
  logic        hold_pending = 1'b0;
  logic [63:0] held_pc;
  logic [31:0] held_inst;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h00500093;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  // Synchronous memory, one-cycle read latency.
  always @(posedge clk) if (imem_req) imem_rdata <= mem_word(imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    if (!model_err)
      while (sb.size() < 4) begin
        sb.push_back(next_exp);
        next_exp = next_exp + 64'd4;
      end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (err_next) begin
      model_err = 1'b1;
      err_next  = 1'b0;
    end
    refill();
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    model_err    = 1'b0;
    err_next     = 1'b0;
    hold_pending = 1'b0;
    sb.delete();
    next_exp     = RP;
    refill();
  endtask

  task automatic reset_cycle();
    cycle();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    smp();
    release_reset();
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    if (!model_err) begin
      sb.delete();
      if (pc[1:0] == 2'b00) next_exp = pc;
      else                  err_next = 1'b1;
    end
  endtask

  // Monitor: pops the scoreboard on each accepted word and checks stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (model_err) begin
        chk("err_if_valid", if_valid, 1'b0);
        chk("err_flag", fetch_err, 1'b1);
      end else begin
        if (hold_pending) begin
          chk("hold_valid", if_valid, 1'b1);
          chk("hold_pc", if_pc, held_pc);
          chk("hold_inst", if_inst, held_inst);
        end
        hold_pending = if_valid && !id_ready && !redirect_valid;
        held_pc      = if_pc;
        held_inst    = if_inst;
        if (if_valid && id_ready && !redirect_valid) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", if_pc, 64'hDEAD);
          end else begin
            logic [63:0] e;
            e = sb.pop_front();
            chk("deliver_pc", if_pc, e);
            chk("deliver_inst", if_inst, mem_word(e));
            pops++;
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0;
    repeat (2) smp();
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_if_pc", if_pc, 64'h0);
    chk("rst_fetch_err", fetch_err, 1'b0);

    // First fetch after reset and steady one-per-cycle delivery.
    release_reset();
    smp();
    chk("c0_req", imem_req, 1'b1);
    chk("c0_addr", imem_addr, RP);
    cycle(); smp();
    for (int c = 2; c <= 5; c++) begin
      cycle(); smp();
      chk("stream_valid", if_valid, 1'b1);
      chk("stream_pc", if_pc, RP + 64'(4 * (c - 2)));
      if (c == 2) chk("first_inst", if_inst, 32'h00500093);
    end

    // Stall from cycle 2 for 5 cycles.
    reset_cycle();
    smp();
    cycle(); smp();
    cycle(); id_ready = 1'b0; smp();
    chk("stall_c2_pc", if_pc, RP);
    for (int c = 3; c <= 6; c++) begin
      cycle(); smp();
      chk("stall_pc", if_pc, RP);
      chk("stall_req", imem_req, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(); id_ready = 1'b1; smp();
      chk("resume_valid", if_valid, 1'b1);
      chk("resume_pc", if_pc, RP + 64'(4 * k));
    end

    // Redirect with a full queue.
    for (int k = 0; k < 3; k++) begin cycle(); id_ready = 1'b0; smp(); end
    chk("full_req", imem_req, 1'b0);
    cycle(); id_ready = 1'b1; do_redirect(64'h40); smp();
    chk("redir_req_low", imem_req, 1'b0);
    cycle(); redirect_valid = 1'b0; smp();
    chk("redir_valid_low", if_valid, 1'b0);
    chk("redir_req", imem_req, 1'b1);
    chk("redir_addr", imem_addr, 64'h40);
    cycle(); smp();
    chk("redir_valid_low2", if_valid, 1'b0);
    cycle(); smp();
    chk("redir_valid", if_valid, 1'b1);
    chk("redir_pc", if_pc, 64'h40);

    // Redirect to the top of the address space with a word in flight.
    cycle(); do_redirect(64'hFFFF_FFFF_FFFF_FFFC); smp();
    cycle(); redirect_valid = 1'b0; smp();
    chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(); smp();
    for (int k = 0; k < 3; k++) begin
      cycle(); smp();
      chk("wrap_valid", if_valid, 1'b1);
      chk("wrap_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC + 64'(4 * k));
    end

    // Misaligned redirect is sticky; a later aligned redirect is ignored.
    cycle(); do_redirect(64'h42); smp();
    cycle(); redirect_valid = 1'b0; smp();
    chk("err_set", fetch_err, 1'b1);
    chk("err_req", imem_req, 1'b0);
    cycle(); do_redirect(64'h80); smp();
    chk("err_redir_req", imem_req, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(); redirect_valid = 1'b0; smp();
      chk("err_hold_req", imem_req, 1'b0);
      chk("err_hold_valid", if_valid, 1'b0);
    end

    // Asynchronous reset pulse with a full queue.
    reset_cycle();
    id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin cycle(); smp(); end
    chk("prefull_valid", if_valid, 1'b1);
    cycle();
    rst_n = 1'b0;
    #1;
    chk("arst_req", imem_req, 1'b0);
    chk("arst_valid", if_valid, 1'b0);
    chk("arst_inst", if_inst, 32'h0);
    chk("arst_pc", if_pc, 64'h0);
    chk("arst_err", fetch_err, 1'b0);
    release_reset();
    id_ready = 1'b1;
    smp();
    chk("restart_req", imem_req, 1'b1);
    chk("restart_addr", imem_addr, RP);
    cycle(); smp();
    cycle(); smp();
    chk("restart_pc", if_pc, RP);

    // Randomized stalls and aligned redirects.
    for (int n = 0; n < 1500; n++) begin
      cycle();
      id_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 3) == 0) do_redirect(64'hFFFF_FFFF_FFFF_FFF0);
        else do_redirect({$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC);
      end else begin
        redirect_valid = 1'b0;
      end
      smp();
    end
    cycle(); redirect_valid = 1'b0; smp();
    chk("progress", 64'(pops > 300), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
